// File: rtl/tlp_reg_req_decoder.sv
// RX TLP parser: collects 3DW/4DW headers from the PCIe RX stream, turns 1-DW BAR0
// MemRd/MemWr accesses into a channel/offset register request, and counts everything else.
module tlp_reg_req_decoder #(
  parameter int DATA_W      = 64,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int TUSER_W     = 22,
  parameter int CHNL_NUM    = 12,
  parameter int BAR_HIT_BIT = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               s_axis_rx_tready,
  input  logic [DATA_W-1:0]  s_axis_rx_tdata,
  input  logic [KEEP_W-1:0]  s_axis_rx_tkeep,
  input  logic               s_axis_rx_sop,
  input  logic               s_axis_rx_eop,
  input  logic               s_axis_rx_tvalid,
  input  logic [TUSER_W-1:0] s_axis_rx_tuser,
  output logic               req_valid,
  input  logic               req_ready,
  output logic               req_wr,
  output logic [3:0]         req_chnl,
  output logic [3:0]         req_off,
  output logic [31:0]        req_data,
  output logic [3:0]         req_be,
  output logic [15:0]        req_rid,
  output logic [7:0]         req_tag,
  output logic [2:0]         req_tc,
  output logic [1:0]         req_attr,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int BEAT_DW = DATA_W / 32;

  typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

  state_t      state, state_n;
  logic        beat;
  logic        capture;
  logic        accept;
  logic [1:0]  drop_add;
  logic [3:0]  dw_idx;
  logic [3:0]  base;
  logic [3:0]  rcvd;
  logic [3:0]  need;
  logic [31:0] hdr_q [5];
  logic [31:0] hdr_n [5];
  logic        bar_q;
  logic        bar_cur;
  logic [1:0]  fmt;
  logic [4:0]  tlp_type;
  logic [9:0]  len;
  logic        is_4dw;
  logic        is_wr;
  logic [31:0] addr;
  logic [31:0] payload;
  logic        tlp_ok;
  logic [CNT_W:0] drop_sum;
  logic        unused_bits;

  assign s_axis_rx_tready = (state != OUT);
  assign req_valid        = (state == OUT);
  assign beat             = s_axis_rx_tvalid && s_axis_rx_tready;

  // Header store as it will look once the current beat is written; the eop decision uses it.
  always_comb begin
    base = s_axis_rx_sop ? 4'd0 : dw_idx;
    rcvd = base + 4'(BEAT_DW);
    for (int k = 0; k < 5; k++) begin
      hdr_n[k] = hdr_q[k];
      for (int j = 0; j < BEAT_DW; j++) begin
        if (base + 4'(j) == 4'(k)) hdr_n[k] = s_axis_rx_tdata[32*j +: 32];
      end
    end
  end

  always_comb begin
    bar_cur  = s_axis_rx_sop ? s_axis_rx_tuser[BAR_HIT_BIT] : bar_q;
    fmt      = hdr_n[0][30:29];
    tlp_type = hdr_n[0][28:24];
    len      = hdr_n[0][9:0];
    is_4dw   = fmt[0];
    is_wr    = fmt[1];
    need     = 4'd3 + {3'b0, is_4dw} + {3'b0, is_wr};
    addr     = is_4dw ? hdr_n[3] : hdr_n[2];
    payload  = is_wr ? (is_4dw ? hdr_n[4] : hdr_n[3]) : 32'd0;
    tlp_ok   = (tlp_type == 5'b00000) && (len == 10'd1) && bar_cur &&
               ({1'b0, addr[9:6]} < 5'(CHNL_NUM)) && (rcvd >= need);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A sop seen while still collecting abandons the old packet, which counts as a drop.
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    accept   = 1'b0;
    drop_add = 2'd0;
    case (state)
      IDLE: begin
        if (beat && s_axis_rx_sop) begin
          capture = 1'b1;
          if (s_axis_rx_eop) begin
            if (tlp_ok) begin
              accept  = 1'b1;
              state_n = OUT;
            end else begin
              drop_add = 2'd1;
            end
          end else begin
            state_n = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (beat) begin
          capture  = 1'b1;
          drop_add = {1'b0, s_axis_rx_sop};
          if (s_axis_rx_eop) begin
            if (tlp_ok) begin
              accept  = 1'b1;
              state_n = OUT;
            end else begin
              drop_add = drop_add + 2'd1;
              state_n  = IDLE;
            end
          end
        end
      end
      OUT: begin
        if (req_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_add);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) hdr_q[k] <= 32'd0;
      dw_idx   <= 4'd0;
      bar_q    <= 1'b0;
      req_wr   <= 1'b0;
      req_chnl <= 4'd0;
      req_off  <= 4'd0;
      req_data <= 32'd0;
      req_be   <= 4'd0;
      req_rid  <= 16'd0;
      req_tag  <= 8'd0;
      req_tc   <= 3'd0;
      req_attr <= 2'd0;
      drop_cnt <= '0;
    end else begin
      if (capture) begin
        for (int k = 0; k < 5; k++) hdr_q[k] <= hdr_n[k];
        dw_idx <= (rcvd > 4'd8) ? 4'd8 : rcvd;
        if (s_axis_rx_sop) bar_q <= s_axis_rx_tuser[BAR_HIT_BIT];
      end
      if (accept) begin
        req_wr   <= is_wr;
        req_chnl <= addr[9:6];
        req_off  <= addr[5:2];
        req_data <= payload;
        req_be   <= hdr_n[1][3:0];
        req_rid  <= hdr_n[1][31:16];
        req_tag  <= hdr_n[1][15:8];
        req_tc   <= hdr_n[0][22:20];
        req_attr <= hdr_n[0][13:12];
      end
      if (drop_add != 2'd0) drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  assign unused_bits = ^{s_axis_rx_tkeep, s_axis_rx_tuser, hdr_n[0], hdr_n[1], addr};

endmodule

// File: tb/tb_tlp_reg_req_decoder.sv
// Directed bench for tlp_reg_req_decoder: four instances (64b/CH12, 128b/CH16, 32b/CH12,
// 128b/CH12) share the RX stimulus bus; each test drives one of them.
module tb_tlp_reg_req_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         sop, eop;
  logic [21:0]  tuser;
  logic         req_ready;
  logic [3:0]   tvalid_v;
  logic [3:0]   tready_v;
  logic [3:0]   req_valid_v;
  logic [3:0]   req_wr_v;
  logic [3:0]   req_chnl_v [4];
  logic [3:0]   req_off_v  [4];
  logic [3:0]   req_be_v   [4];
  logic [31:0]  req_data_v [4];
  logic [15:0]  req_rid_v  [4];
  logic [7:0]   req_tag_v  [4];
  logic [2:0]   req_tc_v   [4];
  logic [1:0]   req_attr_v [4];
  logic [15:0]  drop_v     [4];

  int errors = 0;
  int checks = 0;
  logic [31:0] pkt [8];
  int pkt_n;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 1 || g == 3) ? 128 : ((g == 2) ? 32 : 64);
    localparam int C = (g == 1) ? 16 : 12;
    tlp_reg_req_decoder #(
      .DATA_W(W), .KEEP_W(W / 8), .TUSER_W(22), .CHNL_NUM(C), .BAR_HIT_BIT(2), .CNT_W(16)
    ) u_dut (
      .clk(clk), .rst(rst),
      .s_axis_rx_tready(tready_v[g]),
      .s_axis_rx_tdata(tdata[W-1:0]),
      .s_axis_rx_tkeep(tkeep[W/8-1:0]),
      .s_axis_rx_sop(sop), .s_axis_rx_eop(eop),
      .s_axis_rx_tvalid(tvalid_v[g]),
      .s_axis_rx_tuser(tuser),
      .req_valid(req_valid_v[g]), .req_ready(req_ready),
      .req_wr(req_wr_v[g]), .req_chnl(req_chnl_v[g]), .req_off(req_off_v[g]),
      .req_data(req_data_v[g]), .req_be(req_be_v[g]), .req_rid(req_rid_v[g]),
      .req_tag(req_tag_v[g]), .req_tc(req_tc_v[g]), .req_attr(req_attr_v[g]),
      .drop_cnt(drop_v[g])
    );
  end

  function automatic int dw_of(input int d);
    return (d == 1 || d == 3) ? 4 : ((d == 2) ? 1 : 2);
  endfunction

  function automatic logic [31:0] mk_dw0(input logic [1:0] fmt, input logic [4:0] typ,
                                         input logic [2:0] tc, input logic [1:0] attr,
                                         input logic [9:0] len);
    return {1'b0, fmt, typ, 1'b0, tc, 6'b0, attr, 2'b0, len};
  endfunction

  function automatic logic [31:0] mk_dw1(input logic [15:0] rid, input logic [7:0] tag,
                                         input logic [3:0] be);
    return {rid, tag, 4'h0, be};
  endfunction

  task automatic send_beat(input int d, input logic [127:0] data, input logic s, input logic e,
                           input logic bar, output int stalls);
    int n;
    tdata = data;
    sop = s;
    eop = e;
    tuser = '0;
    tuser[2] = bar;
    tvalid_v[d] = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tready_v[d]) break;
    end
    stalls = n;
    checks++;
    if (tready_v[d] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL beat_accept dut%0d: tready=%b after %0d cycles, required 1", d, tready_v[d], n);
    end
    @(posedge clk);
    #1;
    tvalid_v[d] = 1'b0;
    sop = 1'b0;
    eop = 1'b0;
  endtask

  task automatic send_tlp(input int d, input logic bar, output int stalls);
    int w, nb, st;
    logic [127:0] data;
    w = dw_of(d);
    nb = (pkt_n + w - 1) / w;
    stalls = 0;
    for (int b = 0; b < nb; b++) begin
      data = '0;
      for (int j = 0; j < w; j++)
        if (b * w + j < pkt_n) data[32*j +: 32] = pkt[b * w + j];
      send_beat(d, data, b == 0, b == nb - 1, bar, st);
      stalls += st;
    end
  endtask

  task automatic consume();
    req_ready = 1'b1;
    @(posedge clk);
    #1;
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++; if (tready_v[d] !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready dut%0d: got %b want 1", d, tready_v[d]); end
      checks++; if (req_valid_v[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid dut%0d: got %b want 0", d, req_valid_v[d]); end
      checks++; if (drop_v[d] !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop dut%0d: got %0d want 0", d, drop_v[d]); end
      checks++; if ({req_wr_v[d], req_chnl_v[d], req_off_v[d], req_data_v[d], req_be_v[d], req_rid_v[d], req_tag_v[d], req_tc_v[d], req_attr_v[d]} !== '0) begin
        errors++; $display("[TB] FAIL reset_req dut%0d: data=%h rid=%h tag=%h want all zero", d, req_data_v[d], req_rid_v[d], req_tag_v[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mwr_64();
    int st;
    pkt[0] = mk_dw0(2'b10, 5'd0, 3'd3, 2'd1, 10'd1);
    pkt[1] = mk_dw1(16'hABCD, 8'h11, 4'hF);
    pkt[2] = 32'h0000_0184;
    pkt[3] = 32'hDEAD_BEEF;
    pkt_n = 4;
    send_tlp(0, 1'b1, st);
    checks++; if (req_valid_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL mwr64_valid: got %b want 1", req_valid_v[0]); end
    checks++; if (req_wr_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL mwr64_wr: got %b want 1", req_wr_v[0]); end
    checks++; if (req_chnl_v[0] !== 4'd6) begin errors++; $display("[TB] FAIL mwr64_chnl: got %0d want 6", req_chnl_v[0]); end
    checks++; if (req_off_v[0] !== 4'd1) begin errors++; $display("[TB] FAIL mwr64_off: got %0d want 1", req_off_v[0]); end
    checks++; if (req_data_v[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mwr64_data: got %h want deadbeef", req_data_v[0]); end
    checks++; if (req_be_v[0] !== 4'hF) begin errors++; $display("[TB] FAIL mwr64_be: got %h want f", req_be_v[0]); end
    checks++; if (req_rid_v[0] !== 16'hABCD) begin errors++; $display("[TB] FAIL mwr64_rid: got %h want abcd", req_rid_v[0]); end
    checks++; if (req_tag_v[0] !== 8'h11) begin errors++; $display("[TB] FAIL mwr64_tag: got %h want 11", req_tag_v[0]); end
    checks++; if (req_tc_v[0] !== 3'd3) begin errors++; $display("[TB] FAIL mwr64_tc: got %0d want 3", req_tc_v[0]); end
    checks++; if (req_attr_v[0] !== 2'd1) begin errors++; $display("[TB] FAIL mwr64_attr: got %0d want 1", req_attr_v[0]); end
    checks++; if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL mwr64_drop: got %0d want 0", drop_v[0]); end
    consume();
    checks++; if (req_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL mwr64_release: valid got %b want 0", req_valid_v[0]); end
    checks++; if (tready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL mwr64_tready: got %b want 1", tready_v[0]); end
  endtask

  task automatic test_chnl_boundary();
    int st;
    pkt[0] = mk_dw0(2'b01, 5'd0, 3'd0, 2'd0, 10'd1);
    pkt[1] = mk_dw1(16'h0100, 8'h2A, 4'hF);
    pkt[2] = 32'h0000_0000;
    pkt[3] = 32'h0000_03FC;
    pkt_n = 4;
    send_tlp(3, 1'b1, st);
    checks++; if (req_valid_v[3] !== 1'b0) begin errors++; $display("[TB] FAIL chnl12_valid: got %b want 0", req_valid_v[3]); end
    checks++; if (drop_v[3] !== 16'd1) begin errors++; $display("[TB] FAIL chnl12_drop: got %0d want 1", drop_v[3]); end
    send_tlp(1, 1'b1, st);
    checks++; if (req_valid_v[1] !== 1'b1) begin errors++; $display("[TB] FAIL chnl16_valid: got %b want 1", req_valid_v[1]); end
    checks++; if (req_wr_v[1] !== 1'b0) begin errors++; $display("[TB] FAIL chnl16_wr: got %b want 0", req_wr_v[1]); end
    checks++; if (req_chnl_v[1] !== 4'd15) begin errors++; $display("[TB] FAIL chnl16_chnl: got %0d want 15", req_chnl_v[1]); end
    checks++; if (req_off_v[1] !== 4'd15) begin errors++; $display("[TB] FAIL chnl16_off: got %0d want 15", req_off_v[1]); end
    checks++; if (req_tag_v[1] !== 8'h2A) begin errors++; $display("[TB] FAIL chnl16_tag: got %h want 2a", req_tag_v[1]); end
    checks++; if (req_rid_v[1] !== 16'h0100) begin errors++; $display("[TB] FAIL chnl16_rid: got %h want 0100", req_rid_v[1]); end
    checks++; if (req_data_v[1] !== 32'd0) begin errors++; $display("[TB] FAIL chnl16_data: got %h want 0", req_data_v[1]); end
    consume();
  endtask

  task automatic test_backpressure();
    int st;
    pkt[0] = mk_dw0(2'b11, 5'd0, 3'd5, 2'd2, 10'd1);
    pkt[1] = mk_dw1(16'h1234, 8'h7E, 4'h3);
    pkt[2] = 32'h0000_0000;
    pkt[3] = 32'h0000_0048;
    pkt[4] = 32'h1234_5678;
    pkt_n = 5;
    req_ready = 1'b0;
    send_tlp(2, 1'b1, st);
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_valid_v[2] !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cycle%0d: got %b want 1", i, req_valid_v[2]); end
      checks++; if (tready_v[2] !== 1'b0) begin errors++; $display("[TB] FAIL bp_tready cycle%0d: got %b want 0", i, tready_v[2]); end
      checks++; if ({req_wr_v[2], req_chnl_v[2], req_off_v[2], req_data_v[2], req_be_v[2], req_tag_v[2], req_tc_v[2], req_attr_v[2]} !== {1'b1, 4'd1, 4'd2, 32'h1234_5678, 4'h3, 8'h7E, 3'd5, 2'd2}) begin
        errors++; $display("[TB] FAIL bp_fields cycle%0d: chnl=%0d off=%0d data=%h be=%h tag=%h want 1 2 12345678 3 7e", i, req_chnl_v[2], req_off_v[2], req_data_v[2], req_be_v[2], req_tag_v[2]);
      end
      @(posedge clk);
      #1;
    end
    consume();
    checks++; if (req_valid_v[2] !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: valid got %b want 0", req_valid_v[2]); end
    checks++; if (tready_v[2] !== 1'b1) begin errors++; $display("[TB] FAIL bp_tready_after: got %b want 1", tready_v[2]); end
    checks++; if (drop_v[2] !== 16'd0) begin errors++; $display("[TB] FAIL bp_drop: got %0d want 0", drop_v[2]); end
  endtask

  task automatic test_drops();
    int st;
    pkt[0] = mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd2);
    pkt[1] = mk_dw1(16'h0001, 8'h01, 4'hF);
    pkt[2] = 32'h0000_0184;
    pkt[3] = 32'h1111_1111;
    pkt[4] = 32'h2222_2222;
    pkt_n = 5;
    send_tlp(0, 1'b1, st);
    checks++; if (req_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL drop_len_valid: got %b want 0", req_valid_v[0]); end
    checks++; if (drop_v[0] !== 16'd1) begin errors++; $display("[TB] FAIL drop_len_cnt: got %0d want 1", drop_v[0]); end
    pkt[0] = mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd1);
    pkt_n = 3;
    send_tlp(0, 1'b0, st);
    checks++; if (req_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL drop_bar_valid: got %b want 0", req_valid_v[0]); end
    checks++; if (drop_v[0] !== 16'd2) begin errors++; $display("[TB] FAIL drop_bar_cnt: got %0d want 2", drop_v[0]); end
    pkt[0] = mk_dw0(2'b10, 5'b01010, 3'd0, 2'd0, 10'd1);
    pkt_n = 4;
    send_tlp(0, 1'b1, st);
    checks++; if (req_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL drop_cpl_valid: got %b want 0", req_valid_v[0]); end
    checks++; if (drop_v[0] !== 16'd3) begin errors++; $display("[TB] FAIL drop_cpl_cnt: got %0d want 3", drop_v[0]); end
  endtask

  task automatic test_back_to_back();
    int st1, st2;
    req_ready = 1'b1;
    pkt[0] = mk_dw0(2'b00, 5'd0, 3'd0, 2'd0, 10'd1);
    pkt[1] = mk_dw1(16'h0A0B, 8'h01, 4'hF);
    pkt[2] = 32'h0000_0040;
    pkt_n = 3;
    send_tlp(1, 1'b1, st1);
    checks++; if (st1 !== 0) begin errors++; $display("[TB] FAIL b2b_stall1: got %0d want 0", st1); end
    checks++; if ({req_valid_v[1], req_wr_v[1], req_chnl_v[1], req_off_v[1], req_tag_v[1]} !== {1'b1, 1'b0, 4'd1, 4'd0, 8'h01}) begin
      errors++; $display("[TB] FAIL b2b_req1: valid=%b chnl=%0d off=%0d tag=%h want 1 1 0 01", req_valid_v[1], req_chnl_v[1], req_off_v[1], req_tag_v[1]);
    end
    pkt[1] = mk_dw1(16'h0A0B, 8'h02, 4'hF);
    pkt[2] = 32'h0000_02C8;
    send_tlp(1, 1'b1, st2);
    checks++; if (st2 !== 1) begin errors++; $display("[TB] FAIL b2b_stall2: got %0d want 1", st2); end
    checks++; if ({req_valid_v[1], req_wr_v[1], req_chnl_v[1], req_off_v[1], req_tag_v[1]} !== {1'b1, 1'b0, 4'd11, 4'd2, 8'h02}) begin
      errors++; $display("[TB] FAIL b2b_req2: valid=%b chnl=%0d off=%0d tag=%h want 1 11 2 02", req_valid_v[1], req_chnl_v[1], req_off_v[1], req_tag_v[1]);
    end
    @(posedge clk);
    #1;
    checks++; if (req_valid_v[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release: valid got %b want 0", req_valid_v[1]); end
    checks++; if (tready_v[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tready: got %b want 1", tready_v[1]); end
    req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    int st;
    pkt[0] = mk_dw0(2'b10, 5'd0, 3'd0, 2'd0, 10'd1);
    pkt[1] = mk_dw1(16'h00FF, 8'h33, 4'hC);
    pkt[2] = 32'h0000_02A0;
    pkt[3] = 32'hCAFE_F00D;
    pkt_n = 4;
    send_beat(0, {64'd0, pkt[1], pkt[0]}, 1'b1, 1'b0, 1'b1, st);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b want 0", req_valid_v[0]); end
    checks++; if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_drop_cleared: got %0d want 0", drop_v[0]); end
    rst = 1'b0;
    send_beat(0, {64'd0, pkt[3], pkt[2]}, 1'b0, 1'b1, 1'b1, st);
    checks++; if (req_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stray_valid: got %b want 0", req_valid_v[0]); end
    checks++; if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_stray_drop: got %0d want 0", drop_v[0]); end
    send_tlp(0, 1'b1, st);
    checks++; if ({req_valid_v[0], req_wr_v[0], req_chnl_v[0], req_off_v[0], req_data_v[0], req_be_v[0]} !== {1'b1, 1'b1, 4'd10, 4'd8, 32'hCAFE_F00D, 4'hC}) begin
      errors++; $display("[TB] FAIL rstmid_fresh: valid=%b chnl=%0d off=%0d data=%h be=%h want 1 10 8 cafef00d c", req_valid_v[0], req_chnl_v[0], req_off_v[0], req_data_v[0], req_be_v[0]);
    end
    checks++; if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_drop: got %0d want 0", drop_v[0]); end
    consume();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tdata = '0;
    tkeep = '1;
    sop = 1'b0;
    eop = 1'b0;
    tuser = '0;
    tvalid_v = '0;
    req_ready = 1'b0;
    test_reset();
    test_mwr_64();
    test_chnl_boundary();
    test_backpressure();
    test_drops();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
